// File: rtl/ysyx_23060096_wbu.sv
// Writeback unit: buffers EXU and LSU results in 2-entry FIFOs and round-robins them onto the RF write port.
// Optional macro YSYX_23060096_WBU_BYPASS_EN adds byp_* forwarding outputs mirroring the RF write.

module ysyx_23060096_wbu_fifo #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         ready,
    output logic         nempty,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;

    always_comb begin
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= 2'd0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // ready looks only at registered occupancy, so a full FIFO refuses even when popping
    assign ready  = (cnt_q < 2'd2);
    assign nempty = (cnt_q != 2'd0);
    assign rdata  = mem_q[rptr_q];
endmodule

module ysyx_23060096_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic [DATA_WIDTH-1:0] exu_pc,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic [DATA_WIDTH-1:0] lsu_pc,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef YSYX_23060096_WBU_BYPASS_EN
    output logic                  byp_valid,
    output logic [ADDR_WIDTH-1:0] byp_rd,
    output logic [DATA_WIDTH-1:0] byp_data,
`endif
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc
);
    localparam int EW = ADDR_WIDTH + 1 + 2 * DATA_WIDTH;

    logic [EW-1:0]         exu_rdata, lsu_rdata;
    logic                  exu_nempty, lsu_nempty;
    logic                  pop_exu, pop_lsu;
    logic [ADDR_WIDTH-1:0] e_rd, l_rd;
    logic                  e_wen, l_wen;
    logic [DATA_WIDTH-1:0] e_data, l_data, e_pc, l_pc;

    logic                  rr_q, rr_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  commit_valid_q, commit_valid_d;
    logic [DATA_WIDTH-1:0] commit_pc_q, commit_pc_d;

    ysyx_23060096_wbu_fifo #(.W(EW)) u_exu_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (exu_valid && exu_ready),
        .pop    (pop_exu),
        .wdata  ({exu_rd, exu_wen, exu_data, exu_pc}),
        .ready  (exu_ready),
        .nempty (exu_nempty),
        .rdata  (exu_rdata)
    );

    ysyx_23060096_wbu_fifo #(.W(EW)) u_lsu_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (lsu_valid && lsu_ready),
        .pop    (pop_lsu),
        .wdata  ({lsu_rd, lsu_wen, lsu_data, lsu_pc}),
        .ready  (lsu_ready),
        .nempty (lsu_nempty),
        .rdata  (lsu_rdata)
    );

    assign {e_rd, e_wen, e_data, e_pc} = exu_rdata;
    assign {l_rd, l_wen, l_data, l_pc} = lsu_rdata;

    // rr=0 favours LSU; after a contested grant rr points at the loser
    always_comb begin
        pop_exu = 1'b0;
        pop_lsu = 1'b0;
        rr_d    = rr_q;
        if (exu_nempty && lsu_nempty) begin
            if (rr_q) begin
                pop_exu = 1'b1;
                rr_d    = 1'b0;
            end else begin
                pop_lsu = 1'b1;
                rr_d    = 1'b1;
            end
        end else if (exu_nempty) begin
            pop_exu = 1'b1;
        end else if (lsu_nempty) begin
            pop_lsu = 1'b1;
        end
    end

    always_comb begin
        commit_valid_d = pop_exu || pop_lsu;
        commit_pc_d    = commit_pc_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        if (pop_lsu) begin
            commit_pc_d = l_pc;
            rf_wen_d    = l_wen && (l_rd != '0);
            rf_waddr_d  = l_rd;
            rf_wdata_d  = l_data;
        end else if (pop_exu) begin
            commit_pc_d = e_pc;
            rf_wen_d    = e_wen && (e_rd != '0);
            rf_waddr_d  = e_rd;
            rf_wdata_d  = e_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q           <= 1'b0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            rr_q           <= rr_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;

`ifdef YSYX_23060096_WBU_BYPASS_EN
    assign byp_valid = rf_wen_q;
    assign byp_rd    = rf_waddr_q;
    assign byp_data  = rf_wdata_q;
`endif
endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Bench for ysyx_23060096_wbu: queue-based reference model checked every cycle plus directed literal checks.
// Define YSYX_23060096_WBU_BYPASS_EN to also exercise the byp_* outputs.

module tb_ysyx_23060096_wbu;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exu_valid, lsu_valid, exu_wen, lsu_wen;
    logic          exu_ready, lsu_ready;
    logic [AW-1:0] exu_rd, lsu_rd;
    logic [DW-1:0] exu_data, lsu_data, exu_pc, lsu_pc;
    logic          rf_wen, commit_valid;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, commit_pc;
`ifdef YSYX_23060096_WBU_BYPASS_EN
    logic          byp_valid;
    logic [AW-1:0] byp_rd;
    logic [DW-1:0] byp_data;
`endif

    always #5 clk = ~clk;

    ysyx_23060096_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_wen      (exu_wen),
        .exu_data     (exu_data),
        .exu_pc       (exu_pc),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_wen      (lsu_wen),
        .lsu_data     (lsu_data),
        .lsu_pc       (lsu_pc),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
`ifdef YSYX_23060096_WBU_BYPASS_EN
        .byp_valid    (byp_valid),
        .byp_rd       (byp_rd),
        .byp_data     (byp_data),
`endif
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: one queue per channel, rr bit, registered expected outputs
    typedef struct {
        logic [AW-1:0] rd;
        logic          wen;
        logic [DW-1:0] data;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t          mq_e[$];
    ent_t          mq_l[$];
    bit            m_rr = 1'b0;
    logic          m_cv = 1'b0, m_wen = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_pc = '0;

    always @(posedge clk or posedge rst) begin
        ent_t g;
        bit   have, e_ok, l_ok;
        if (rst) begin
            mq_e.delete();
            mq_l.delete();
            m_rr = 1'b0; m_cv = 1'b0; m_wen = 1'b0;
            m_addr = '0; m_data = '0; m_pc = '0;
        end else begin
            e_ok = mq_e.size() < 2;
            l_ok = mq_l.size() < 2;
            have = 1'b0;
            if (mq_e.size() > 0 && mq_l.size() > 0) begin
                if (m_rr) begin g = mq_e.pop_front(); m_rr = 1'b0; end
                else      begin g = mq_l.pop_front(); m_rr = 1'b1; end
                have = 1'b1;
            end else if (mq_e.size() > 0) begin
                g = mq_e.pop_front(); have = 1'b1;
            end else if (mq_l.size() > 0) begin
                g = mq_l.pop_front(); have = 1'b1;
            end
            if (exu_valid && e_ok) mq_e.push_back('{exu_rd, exu_wen, exu_data, exu_pc});
            if (lsu_valid && l_ok) mq_l.push_back('{lsu_rd, lsu_wen, lsu_data, lsu_pc});
            m_cv  = have;
            m_wen = 1'b0;
            if (have) begin
                m_pc   = g.pc;
                m_wen  = g.wen && (g.rd != 0);
                m_addr = g.rd;
                m_data = g.data;
            end
        end
    end

    // Per-cycle compare plus a log of observed commits
    logic [DW-1:0] log_pc[$];
    logic          log_wen[$];
    int            log_cyc[$];
    int            cyc = 0;
    int            exu_stall = 0;

    always @(negedge clk) begin
        cyc++;
        chk("commit_valid", commit_valid, m_cv);
        if (m_cv) chk("commit_pc", commit_pc, m_pc);
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("exu_ready", exu_ready, mq_e.size() < 2);
        chk("lsu_ready", lsu_ready, mq_l.size() < 2);
`ifdef YSYX_23060096_WBU_BYPASS_EN
        chk("byp_valid", byp_valid, m_wen);
        chk("byp_rd", byp_rd, m_addr);
        chk("byp_data", byp_data, m_data);
`endif
        if (commit_valid) begin
            log_pc.push_back(commit_pc);
            log_wen.push_back(rf_wen);
            log_cyc.push_back(cyc);
        end
        if (!exu_ready) exu_stall++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        exu_rd = '0; lsu_rd = '0; exu_wen = 1'b0; lsu_wen = 1'b0;
        exu_data = '0; lsu_data = '0; exu_pc = '0; lsu_pc = '0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_rf_wen"}, rf_wen, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_commit_pc"}, commit_pc, 0);
    endtask

    initial begin
        int base, ne, nl, k_e, k_l, stall0;
        logic [DW-1:0] epc, lpc;
        bit ea, la;

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {exu_ready, lsu_ready}, 2'b11);

        // Single EXU write
        base = log_pc.size();
        exu_valid = 1'b1; exu_rd = 5; exu_wen = 1'b1; exu_data = 32'hDEADBEEF; exu_pc = 32'h8000_0000;
        tick();
        idle();
        tick();
        chk("single_rf_wen", rf_wen, 1);
        chk("single_rf_waddr", rf_waddr, 5);
        chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_commit_valid", commit_valid, 1);
        chk("single_commit_pc", commit_pc, 32'h8000_0000);
        tick();
        chk("single_pulse_end", commit_valid, 0);
        repeat (3) tick();
        chk("single_pulse_count", log_pc.size() - base, 1);

        // x0 and no-write entries still retire
        base = log_pc.size();
        exu_valid = 1'b1; exu_rd = 0; exu_wen = 1'b1; exu_data = 32'h11; exu_pc = 32'h100;
        tick();
        idle();
        lsu_valid = 1'b1; lsu_rd = 3; lsu_wen = 1'b0; lsu_data = 32'h22; lsu_pc = 32'h200;
        tick();
        idle();
        repeat (4) tick();
        chk("x0_count", log_pc.size() - base, 2);
        if (log_pc.size() - base == 2) begin
            chk("x0_pc0", log_pc[base], 32'h100);
            chk("x0_pc1", log_pc[base + 1], 32'h200);
            chk("x0_wen0", log_wen[base], 0);
            chk("x0_wen1", log_wen[base + 1], 0);
        end

        // Contention from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        base = log_pc.size();
        exu_valid = 1'b1; exu_rd = 1; exu_wen = 1'b1; exu_data = 32'hE1; exu_pc = 32'h3000;
        lsu_valid = 1'b1; lsu_rd = 2; lsu_wen = 1'b1; lsu_data = 32'hA1; lsu_pc = 32'h4000;
        tick();
        exu_data = 32'hE2; exu_pc = 32'h3004;
        lsu_data = 32'hA2; lsu_pc = 32'h4004;
        tick();
        idle();
        repeat (6) tick();
        chk("rr_count", log_pc.size() - base, 4);
        if (log_pc.size() - base == 4) begin
            chk("rr_grant0", log_pc[base], 32'h4000);
            chk("rr_grant1", log_pc[base + 1], 32'h3000);
            chk("rr_grant2", log_pc[base + 2], 32'h4004);
            chk("rr_grant3", log_pc[base + 3], 32'h3004);
            chk("rr_back_to_back", log_cyc[base + 3] - log_cyc[base], 3);
        end

        // Backpressure with both channels streaming
        base = log_pc.size();
        stall0 = exu_stall;
        ne = 0; nl = 0;
        epc = 32'h1000; lpc = 32'h2000;
        exu_valid = 1'b1; exu_rd = 6; exu_wen = 1'b1; exu_data = epc; exu_pc = epc;
        lsu_valid = 1'b1; lsu_rd = 9; lsu_wen = 1'b1; lsu_data = lpc; lsu_pc = lpc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ea = exu_ready;
            la = lsu_ready;
            @(posedge clk);
            #1;
            if (ea) begin ne++; epc += 4; exu_pc = epc; exu_data = epc; end
            if (la) begin nl++; lpc += 4; lsu_pc = lpc; lsu_data = lpc; end
        end
        idle();
        repeat (30) tick();
        chk("bp_exu_ready_dropped", exu_stall > stall0, 1);
        chk("bp_total", log_pc.size() - base, ne + nl);
        k_e = 0; k_l = 0;
        for (int i = base; i < log_pc.size(); i++) begin
            if (log_pc[i] < 32'h2000) begin
                chk("bp_exu_order", log_pc[i], 32'h1000 + 4 * k_e);
                k_e++;
            end else begin
                chk("bp_lsu_order", log_pc[i], 32'h2000 + 4 * k_l);
                k_l++;
            end
        end
        chk("bp_exu_count", k_e, ne);
        chk("bp_lsu_count", k_l, nl);

`ifdef YSYX_23060096_WBU_BYPASS_EN
        lsu_valid = 1'b1; lsu_rd = 7; lsu_wen = 1'b1; lsu_data = 32'hCAFE0007; lsu_pc = 32'h500;
        tick();
        idle();
        tick();
        chk("byp_lit_valid", byp_valid, 1);
        chk("byp_lit_rd", byp_rd, 7);
        chk("byp_lit_data", byp_data, 32'hCAFE0007);
        repeat (2) tick();
`endif

        // Reset mid-operation with entries queued
        exu_valid = 1'b1; exu_rd = 4; exu_wen = 1'b1; exu_data = 32'h77; exu_pc = 32'h600;
        lsu_valid = 1'b1; lsu_rd = 8; lsu_wen = 1'b1; lsu_data = 32'h88; lsu_pc = 32'h700;
        repeat (3) tick();
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        base = log_pc.size();
        repeat (5) tick();
        chk("midrst_no_commit", log_pc.size() - base, 0);
        chk("midrst_ready", {exu_ready, lsu_ready}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060096_wbu.md
# ysyx_23060096_wbu

Writeback unit for the NPC core. It collects completed results from two producers, the EXU (ALU/CSR results) and the LSU (load returns), and buffers each in a 2-entry FIFO. It arbitrates the two sources onto the single register-file write port, driving waddr, wdata and w_en, and raises a per-instruction commit pulse for difftest/trace. It sits directly upstream of the register file.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register/PC data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU FIFO can accept
- exu_rd  in  ADDR_WIDTH  destination register
- exu_wen  in  1  instruction writes rd
- exu_data  in  DATA_WIDTH  result value
- exu_pc  in  DATA_WIDTH  instruction PC
- lsu_valid, lsu_ready, lsu_rd, lsu_wen, lsu_data, lsu_pc: same meaning for the LSU channel
- rf_wen  out  1  register-file write enable
- rf_waddr  out  ADDR_WIDTH  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  DATA_WIDTH  PC of the retired instruction

## Operation
- Each channel owns a 2-entry FIFO holding {rd, wen, data, pc}, with 2-bit occupancy and 1-bit read/write pointers that wrap modulo 2.
- Push: valid && ready. ready = (occupancy < 2). ready depends only on registered occupancy, not on same-cycle pop.
- Arbitration: at most one pop per cycle.
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: round-robin via 1-bit rr. rr=0 favours LSU, rr=1 favours EXU. After a contested grant, rr points to the loser.
  - rr is unchanged on uncontested cycles.
- Popped entry is registered to the outputs the next edge:
  - commit_valid=1, commit_pc=pc.
  - rf_wen = wen && (rd != 0).
  - rf_waddr=rd, rf_wdata=data.
- x0 is never written. An entry with rd=0 or wen=0 still retires (commit_valid=1, rf_wen=0).
- With no pop, commit_valid=0 and rf_wen=0. rf_waddr/rf_wdata hold their last values.
- Ordering between channels is not enforced here. Upstream issue logic guarantees no WAW hazard between in-flight EXU and LSU results.

## Timing
- Reset (async assert, sync release): FIFOs empty, rr=0, and rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc all 0. exu_ready=lsu_ready=1 one cycle after reset deasserts.
- Latency: accepted at edge N, sole entry popped in cycle N, outputs valid from edge N+1. The register file commits at edge N+2.
- Throughput: 1 retire/cycle aggregate; each channel sustains 1/cycle when uncontested.
- Full FIFO with a pop in the same cycle: push is still refused that cycle; ready rises the next cycle.
- Empty FIFO with a push in the same cycle: the entry is not poppable until the following cycle, so there is no combinational input-to-output path.
- Reset mid-operation discards all buffered entries without producing commit pulses.

## Configuration
- YSYX_23060096_WBU_BYPASS_EN defined: adds outputs byp_valid (1), byp_rd (ADDR_WIDTH) and byp_data (DATA_WIDTH), equal to rf_wen, rf_waddr and rf_wdata respectively. ID stage uses them to forward the value being written this cycle, since the register file returns the old value until the edge. All three reset to 0.
- Undefined: these ports and their logic are absent. ID stalls one extra cycle on RAW instead.

## Test plan
- Reset: assert rst mid-stream with 2 entries queued -> all outputs 0 immediately, no commit_valid after release, both ready=1.
- Single EXU write: rd=5, wen=1, data=0xDEADBEEF, pc=0x80000000 at edge N -> at edge N+1 rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, commit_valid=1, commit_pc=0x80000000; one pulse only.
- x0/no-write: EXU rd=0 wen=1, then LSU rd=3 wen=0 -> two commit pulses with rf_wen=0 on both.
- Contention: both channels hold 2 entries from reset -> grant order LSU, EXU, LSU, EXU; 4 consecutive commit pulses.
- Backpressure: hold exu_valid=1 with lsu_valid=1 continuously -> exu_ready drops after 2 accepts, no entry lost or duplicated, commit PCs match the push order per channel.
- Bypass build: a write to rd=7 shows byp_valid=1, byp_rd=7, byp_data equal to rf_wdata in the same cycle. The non-bypass build compiles without these ports.
